// File: rtl/encoder_8_to_3_seq.sv
// encoder_8_to_3_seq: captures an 8-bit request vector and emits the index of each set bit, highest first.
// Define ENC_ACTIVE_LOW_IN_EN to treat in_req as active-low.
module encoder_8_to_3_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_req,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_code,
    output logic       out_last,
    output logic [3:0] out_total,
    output logic [7:0] pend,
    output logic       zero_drop
);
    typedef enum logic {IDLE, EMIT} state_t;
    state_t state, state_nxt;
    logic [7:0] vec, pend_nxt;
    logic [3:0] pop, total_nxt;
    logic take, beat;
`ifdef ENC_ACTIVE_LOW_IN_EN
    assign vec = ~in_req;
`else
    assign vec = in_req;
`endif
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == EMIT);
    assign take      = in_valid && in_ready;
    assign beat      = out_valid && out_ready;
    assign out_last  = (pend != 8'd0) && ((pend & (pend - 8'd1)) == 8'd0);
    // Later (higher) set bits overwrite earlier ones, giving bit 7 priority.
    always_comb begin
        out_code = 3'd0;
        pop = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (pend[i]) out_code = 3'(i);
            pop = pop + 4'(vec[i]);
        end
    end
    always_comb begin
        state_nxt = state;
        pend_nxt = pend;
        total_nxt = out_total;
        if (state == IDLE) begin
            if (take && vec != 8'd0) begin
                pend_nxt = vec;
                total_nxt = pop;
                state_nxt = EMIT;
            end
        end else if (beat) begin
            pend_nxt = pend & ~(8'd1 << out_code);
            total_nxt = out_last ? 4'd0 : out_total;
            state_nxt = out_last ? IDLE : EMIT;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pend <= 8'd0;
            out_total <= 4'd0;
            zero_drop <= 1'b0;
        end else begin
            state <= state_nxt;
            pend <= pend_nxt;
            out_total <= total_nxt;
            zero_drop <= take && vec == 8'd0;
        end
    end
endmodule

// File: tb/tb_encoder_8_to_3_seq.sv
// tb_encoder_8_to_3_seq: directed self-checking bench for encoder_8_to_3_seq.
module tb_encoder_8_to_3_seq;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] in_req = 8'd0;
    logic in_ready, out_valid, out_last, zero_drop;
    logic [2:0] out_code;
    logic [3:0] out_total;
    logic [7:0] pend;
    int tests = 0, fails = 0;

    encoder_8_to_3_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_req(in_req),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code), .out_last(out_last),
        .out_total(out_total), .pend(pend), .zero_drop(zero_drop)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] enc(input logic [7:0] v);
`ifdef ENC_ACTIVE_LOW_IN_EN
        return ~v;
`else
        return v;
`endif
    endfunction

    // Inputs change 2 time units after the edge; checks happen 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_req = enc(8'h20); out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick(); settle();
            tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready c%0d got %b exp 0", c, in_ready); end
            tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid c%0d got %b exp 0", c, out_valid); end
            tests++; if (pend !== 8'h00) begin fails++; $display("FAIL reset_pend c%0d got %h exp 00", c, pend); end
        end
        tests++; if (out_code !== 3'd0 || out_last !== 1'b0 || out_total !== 4'd0 || zero_drop !== 1'b0) begin
            fails++; $display("FAIL reset_outs got code=%0d last=%b total=%0d zd=%b exp 0 0 0 0", out_code, out_last, out_total, zero_drop); end
        rst = 1'b0; in_valid = 1'b0; settle();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL release_in_ready got %b exp 1", in_ready); end
        tick();
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_req = enc(8'h20); out_ready = 1'b1; settle();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL single_ready got %b exp 1", in_ready); end
        tick(); in_valid = 1'b0; settle();
        tests++; if (out_valid !== 1'b1 || out_code !== 3'd5 || out_last !== 1'b1 || out_total !== 4'd1 || pend !== 8'h20) begin
            fails++; $display("FAIL single_beat got v=%b code=%0d last=%b total=%0d pend=%h exp 1 5 1 1 20", out_valid, out_code, out_last, out_total, pend); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL single_busy got %b exp 0", in_ready); end
        tick(); settle();
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_total !== 4'd0 || pend !== 8'h00) begin
            fails++; $display("FAIL single_done got v=%b rdy=%b total=%0d pend=%h exp 0 1 0 00", out_valid, in_ready, out_total, pend); end
    endtask

    task automatic test_multi();
        logic [2:0] codes [4] = '{3'd7, 3'd5, 3'd2, 3'd0};
        logic [7:0] pends [4] = '{8'hA5, 8'h25, 8'h05, 8'h01};
        in_valid = 1'b1; in_req = enc(8'hA5); out_ready = 1'b1;
        tick(); in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            settle();
            tests++; if (out_valid !== 1'b1 || out_code !== codes[k] || out_last !== (k == 3) || pend !== pends[k] || out_total !== 4'd4) begin
                fails++; $display("FAIL multi_beat%0d got v=%b code=%0d last=%b pend=%h total=%0d exp 1 %0d %b %h 4",
                                  k, out_valid, out_code, out_last, pend, out_total, codes[k], k == 3, pends[k]); end
            tick();
        end
        settle();
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL multi_done got v=%b rdy=%b exp 0 1", out_valid, in_ready); end
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1; in_req = enc(8'h81); out_ready = 1'b0;
        tick(); in_req = enc(8'hFF);
        for (int c = 0; c < 5; c++) begin
            settle();
            tests++; if (out_valid !== 1'b1 || out_code !== 3'd7 || pend !== 8'h81 || out_last !== 1'b0 || out_total !== 4'd2 || in_ready !== 1'b0) begin
                fails++; $display("FAIL bp_hold%0d got v=%b code=%0d pend=%h last=%b total=%0d rdy=%b exp 1 7 81 0 2 0",
                                  c, out_valid, out_code, pend, out_last, out_total, in_ready); end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1; settle();
        tests++; if (out_code !== 3'd7 || out_last !== 1'b0) begin fails++; $display("FAIL bp_first got code=%0d last=%b exp 7 0", out_code, out_last); end
        tick(); settle();
        tests++; if (out_valid !== 1'b1 || out_code !== 3'd0 || out_last !== 1'b1 || pend !== 8'h01) begin
            fails++; $display("FAIL bp_second got v=%b code=%0d last=%b pend=%h exp 1 0 1 01", out_valid, out_code, out_last, pend); end
        tick(); settle();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_done got v=%b exp 0", out_valid); end
    endtask

    task automatic test_zero();
        settle();
        tests++; if (zero_drop !== 1'b0) begin fails++; $display("FAIL zero_idle got %b exp 0", zero_drop); end
        in_valid = 1'b1; in_req = enc(8'h00); out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick(); settle();
            tests++; if (zero_drop !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
                fails++; $display("FAIL zero_pulse%0d got zd=%b v=%b rdy=%b exp 1 0 1", c, zero_drop, out_valid, in_ready); end
        end
        in_valid = 1'b0;
        tick(); settle();
        tests++; if (zero_drop !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL zero_end got zd=%b v=%b exp 0 0", zero_drop, out_valid); end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_req = enc(8'hFF); out_ready = 1'b1;
        tick(); in_valid = 1'b0; settle();
        tests++; if (out_code !== 3'd7 || out_total !== 4'd8) begin fails++; $display("FAIL mid_beat7 got code=%0d total=%0d exp 7 8", out_code, out_total); end
        tick(); settle();
        tests++; if (out_code !== 3'd6 || pend !== 8'h7F) begin fails++; $display("FAIL mid_beat6 got code=%0d pend=%h exp 6 7f", out_code, pend); end
        tick(); rst = 1'b1; settle();
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL mid_rst_ready got %b exp 0", in_ready); end
        tick(); rst = 1'b0; settle();
        tests++; if (out_valid !== 1'b0 || pend !== 8'h00 || out_total !== 4'd0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL mid_after got v=%b pend=%h total=%0d rdy=%b exp 0 00 0 1", out_valid, pend, out_total, in_ready); end
        tick(); settle();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_no_code5 got v=%b code=%0d exp v=0", out_valid, out_code); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_backpressure();
        test_zero();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
